snn_step_scheduler: RTL and testbench
=====================================

Name: snn_step_scheduler

Overview:
- Top-level sequencer for the LIF neuron datapath.
- On start, runs NUM_STEPS timesteps. In each timestep it visits neurons 0..NUM_NEURONS-1 in order.
- For each neuron it drives the datapath through four phases: memory fetch, accumulate, LIF update, output.
- It also counts emitted spikes, guards every phase with a watchdog, and supports abort.

Parameters:
- NUM_NEURONS, 16, neurons visited per timestep (>=1).
- NUM_STEPS, 8, timesteps per run (>=1).
- TIMEOUT, 255, maximum cycles allowed in any one phase before error (>=1).
- CNT_W, 16, width of the spike counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- start  in  1  begin a run; sampled only in IDLE or ERR.
- abort  in  1  cancel the active run.
- in_done  in  1  input fetch complete.
- we_done  in  1  weight fetch complete.
- add_done  in  1  accumulate complete.
- lif_ready  in  1  LIF update complete.
- out_valid  in  1  output phase complete; spike_in is valid.
- spike_in  in  1  spike result for the current neuron.
- in_en  out  1  input fetch enable (MEM).
- we_en  out  1  weight fetch enable (MEM).
- add_en  out  1  accumulate enable (ADD).
- lif_en  out  1  LIF enable (LIF).
- out_en  out  1  output enable (OUT).
- neuron_idx  out  $clog2(NUM_NEURONS) (min 1)  current neuron.
- step_idx  out  $clog2(NUM_STEPS) (min 1)  current timestep.
- busy  out  1  high in MEM/ADD/LIF/OUT/NEXT.
- done  out  1  one-cycle pulse at run completion.
- error  out  1  watchdog fired; sticky.
- spike_count  out  CNT_W  spikes counted in current/last run.

Behaviour:
- Reset (rst=0, async): state=IDLE. All enables, busy, done and error = 0. neuron_idx, step_idx, spike_count and watchdog = 0.
- Enables are decoded from the registered state only (Moore): asserted in every cycle the state is held, never in two phases at once.
- IDLE:
  - start=1 -> MEM next cycle.
  - Same edge: clear neuron_idx, step_idx and spike_count.
- MEM:
  - in_en=we_en=1.
  - in_done and we_done are captured into sticky flags, so they may arrive in different cycles.
  - Advance to ADD on the cycle both are seen, either as flag or same-cycle input.
  - Flags clear on leaving MEM.
- ADD: add_en=1; add_done -> LIF.
- LIF: lif_en=1; lif_ready -> OUT.
- OUT: out_en=1. On out_valid:
  - spike_count += spike_in, saturating at 2^CNT_W-1.
  - Next state is NEXT.
- NEXT (1 cycle, busy=1, no enables):
  - If neuron_idx < NUM_NEURONS-1: neuron_idx+1 -> MEM.
  - Else neuron_idx=0:
    - If step_idx < NUM_STEPS-1: step_idx+1 -> MEM.
    - Else -> DONE; indices hold their final values.
- DONE: done=1 for exactly one cycle, then IDLE. spike_count holds until the next start.
- Watchdog:
  - Cleared on every state change; counts cycles spent in MEM/ADD/LIF/OUT.
  - When it reaches TIMEOUT without the phase's completion input (i.e. on the (TIMEOUT+1)th cycle in the phase) -> ERR.
  - A completion seen on that same cycle wins; no error.
- ERR:
  - error=1 (sticky), all enables 0, busy=0, indices and spike_count frozen.
  - start=1 -> clear error, indices and count; go to MEM.
- abort=1 in MEM/ADD/LIF/OUT/NEXT -> IDLE next cycle.
  - No done pulse; spike_count holds partial value.
  - abort has priority over completion inputs and the watchdog.
  - abort is ignored in IDLE, DONE and ERR.
- start while busy is ignored.
- Completion inputs outside their own phase are ignored (except MEM flag capture in MEM only).
- Reset mid-run returns immediately to IDLE with all outputs at reset values.
- Per-neuron minimum latency is 5 cycles: MEM, ADD, LIF, OUT, NEXT, with completions asserted on the first cycle of each phase.

Test Plan:
- NUM_NEURONS=2, NUM_STEPS=2, all completions tied high, spike_in=1:
  - start -> 4 neuron visits in order (n,s) = (0,0), (1,0), (0,1), (1,1).
  - done pulses exactly once, 21 cycles after start; spike_count=4.
- MEM split handshake: in_done in cycle 1 of MEM, we_done in cycle 4 -> ADD entered the cycle after cycle 4; in_en/we_en high for exactly 4 cycles.
- Watchdog, TIMEOUT=3: lif_ready held low -> error=1 after 4 cycles in LIF, lif_en=0, busy=0.
  - Then start -> error=0, MEM, indices=0.
- Abort: assert abort in ADD of neuron 1, step 0 -> IDLE next cycle, no done, spike_count retains prior value (1 if neuron 0 spiked).
- Saturation, CNT_W=2, 5 spikes over a run -> spike_count=3.
- Async reset mid-OUT (rst=0 between clock edges) -> out_en drops immediately, all outputs 0. A start after release begins a clean run.

Source files
------------

// File: rtl/snn_step_scheduler_if.sv
// Handshake bundle between the timestep scheduler and the LIF datapath.
// Datapath side drives completions and spike results; scheduler side drives enables and status.
interface snn_step_scheduler_if #(
  parameter int NUM_NEURONS = 16,
  parameter int NUM_STEPS   = 8,
  parameter int CNT_W       = 16
);
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic             start;
  logic             abort;
  logic             in_done;
  logic             we_done;
  logic             add_done;
  logic             lif_ready;
  logic             out_valid;
  logic             spike_in;

  logic             in_en;
  logic             we_en;
  logic             add_en;
  logic             lif_en;
  logic             out_en;
  logic [NW-1:0]    neuron_idx;
  logic [SW-1:0]    step_idx;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] spike_count;

  modport master (
    output start, abort, in_done, we_done, add_done, lif_ready, out_valid, spike_in,
    input  in_en, we_en, add_en, lif_en, out_en, neuron_idx, step_idx,
           busy, done, error, spike_count
  );

  modport slave (
    input  start, abort, in_done, we_done, add_done, lif_ready, out_valid, spike_in,
    output in_en, we_en, add_en, lif_en, out_en, neuron_idx, step_idx,
           busy, done, error, spike_count
  );
endinterface

// File: rtl/snn_step_scheduler.sv
// Sequences MEM/ADD/LIF/OUT/NEXT per neuron over NUM_STEPS timesteps; 5 cycles per neuron minimum.
// Each phase waits on its completion input under a watchdog; abort returns to IDLE, timeout to sticky ERR.
module snn_step_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int NUM_STEPS   = 8,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input logic                clk,
  input logic                rst,
  snn_step_scheduler_if.slave bus
);
  localparam int NW   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int SW   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_ADD,
    S_LIF,
    S_OUT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_flag;
  logic             r_we_flag;
  logic [NW-1:0]    r_neuron;
  logic [SW-1:0]    r_step;
  logic [CNT_W-1:0] r_count;
  logic [WD_W-1:0]  r_wd;

  logic w_mem_ok;
  logic w_wd_expired;
  logic w_last_neuron;
  logic w_last_step;
  logic w_in_phase;
  logic w_run_start;
  logic w_state_chg;

  assign w_mem_ok      = (r_in_flag | bus.in_done) & (r_we_flag | bus.we_done);
  assign w_wd_expired  = (r_wd == WD_W'(TIMEOUT));
  assign w_last_neuron = (r_neuron == NW'(NUM_NEURONS - 1));
  assign w_last_step   = (r_step == SW'(NUM_STEPS - 1));
  assign w_in_phase    = (r_state == S_MEM) || (r_state == S_ADD) ||
                         (r_state == S_LIF) || (r_state == S_OUT);
  assign w_run_start   = ((r_state == S_IDLE) || (r_state == S_ERR)) && bus.start;
  assign w_state_chg   = (w_state_nxt != r_state);

  // Within a phase: abort beats completion, completion beats the watchdog.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_MEM;
      S_MEM: begin
        if (bus.abort)         w_state_nxt = S_IDLE;
        else if (w_mem_ok)     w_state_nxt = S_ADD;
        else if (w_wd_expired) w_state_nxt = S_ERR;
      end
      S_ADD: begin
        if (bus.abort)         w_state_nxt = S_IDLE;
        else if (bus.add_done) w_state_nxt = S_LIF;
        else if (w_wd_expired) w_state_nxt = S_ERR;
      end
      S_LIF: begin
        if (bus.abort)          w_state_nxt = S_IDLE;
        else if (bus.lif_ready) w_state_nxt = S_OUT;
        else if (w_wd_expired)  w_state_nxt = S_ERR;
      end
      S_OUT: begin
        if (bus.abort)          w_state_nxt = S_IDLE;
        else if (bus.out_valid) w_state_nxt = S_NEXT;
        else if (w_wd_expired)  w_state_nxt = S_ERR;
      end
      S_NEXT: begin
        if (bus.abort)                       w_state_nxt = S_IDLE;
        else if (!w_last_neuron || !w_last_step) w_state_nxt = S_MEM;
        else                                 w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      S_ERR:  if (bus.start) w_state_nxt = S_MEM;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd <= '0;
    end else if (w_state_chg) begin
      r_wd <= '0;
    end else if (w_in_phase) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // Fetch completions may arrive in different cycles; hold them until MEM is left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_flag <= 1'b0;
      r_we_flag <= 1'b0;
    end else if ((r_state == S_MEM) && (w_state_nxt == S_MEM)) begin
      r_in_flag <= r_in_flag | bus.in_done;
      r_we_flag <= r_we_flag | bus.we_done;
    end else begin
      r_in_flag <= 1'b0;
      r_we_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neuron <= '0;
      r_step   <= '0;
    end else if (w_run_start) begin
      r_neuron <= '0;
      r_step   <= '0;
    end else if ((r_state == S_NEXT) && (w_state_nxt == S_MEM)) begin
      if (!w_last_neuron) begin
        r_neuron <= r_neuron + NW'(1);
      end else begin
        r_neuron <= '0;
        r_step   <= r_step + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_run_start) begin
      r_count <= '0;
    end else if ((r_state == S_OUT) && (w_state_nxt == S_NEXT) &&
                 bus.spike_in && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.in_en       = (r_state == S_MEM);
  assign bus.we_en       = (r_state == S_MEM);
  assign bus.add_en      = (r_state == S_ADD);
  assign bus.lif_en      = (r_state == S_LIF);
  assign bus.out_en      = (r_state == S_OUT);
  assign bus.busy        = w_in_phase || (r_state == S_NEXT);
  assign bus.done        = (r_state == S_DONE);
  assign bus.error       = (r_state == S_ERR);
  assign bus.neuron_idx  = r_neuron;
  assign bus.step_idx    = r_step;
  assign bus.spike_count = r_count;
endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench: two scheduler instances (2x2 with TIMEOUT=3, and 3x2 with a 2-bit spike counter).
module tb_snn_step_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   a_done_total = 0;
  int   b_done_total = 0;

  always #5 clk = ~clk;

  snn_step_scheduler_if #(.NUM_NEURONS(2), .NUM_STEPS(2), .CNT_W(16)) ifa ();
  snn_step_scheduler_if #(.NUM_NEURONS(3), .NUM_STEPS(2), .CNT_W(2))  ifb ();

  snn_step_scheduler #(.NUM_NEURONS(2), .NUM_STEPS(2), .TIMEOUT(3), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  snn_step_scheduler #(.NUM_NEURONS(3), .NUM_STEPS(2), .TIMEOUT(255), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  always @(negedge clk) begin
    if (ifa.done) a_done_total++;
    if (ifb.done) b_done_total++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic v, input logic spk);
    ifa.in_done   = v;
    ifa.we_done   = v;
    ifa.add_done  = v;
    ifa.lif_ready = v;
    ifa.out_valid = v;
    ifa.spike_in  = spk;
  endtask

  task automatic a_zero_outputs(input string tag);
    chk({tag, " in_en"},  32'(ifa.in_en), 0);
    chk({tag, " we_en"},  32'(ifa.we_en), 0);
    chk({tag, " add_en"}, 32'(ifa.add_en), 0);
    chk({tag, " lif_en"}, 32'(ifa.lif_en), 0);
    chk({tag, " out_en"}, 32'(ifa.out_en), 0);
    chk({tag, " busy"},   32'(ifa.busy), 0);
    chk({tag, " done"},   32'(ifa.done), 0);
    chk({tag, " error"},  32'(ifa.error), 0);
    chk({tag, " nidx"},   32'(ifa.neuron_idx), 0);
    chk({tag, " sidx"},   32'(ifa.step_idx), 0);
    chk({tag, " count"},  32'(ifa.spike_count), 0);
  endtask

  // Full run on instance A with every completion tied high and spike_in=1.
  task automatic run_a(input string tag);
    int     exp_n[4] = '{0, 1, 0, 1};
    int     exp_s[4] = '{0, 0, 1, 1};
    int     cyc = 0;
    int     nvis = 0;
    int     dstart;
    logic   prev_mem = 1'b0;
    a_set(1'b1, 1'b1);
    ifa.start = 1'b1;
    dstart = a_done_total;
    for (int k = 1; k <= 200; k++) begin
      tick();
      ifa.start = 1'b0;
      if (ifa.in_en && !prev_mem) begin
        if (nvis < 4) begin
          chk({tag, " visit nidx"}, 32'(ifa.neuron_idx), exp_n[nvis]);
          chk({tag, " visit sidx"}, 32'(ifa.step_idx), exp_s[nvis]);
        end
        nvis++;
      end
      prev_mem = ifa.in_en;
      if (ifa.done) begin
        cyc = k;
        break;
      end
    end
    chk({tag, " cycles to done"}, 32'(cyc), 21);
    chk({tag, " visits"}, 32'(nvis), 4);
    chk({tag, " count"}, 32'(ifa.spike_count), 4);
    a_set(1'b0, 1'b0);
    tick();
    chk({tag, " done width"}, 32'(ifa.done), 0);
    chk({tag, " idle busy"}, 32'(ifa.busy), 0);
    tick();
    tick();
    chk({tag, " done pulses"}, 32'(a_done_total - dstart), 1);
    chk({tag, " count hold"}, 32'(ifa.spike_count), 4);
  endtask

  initial begin
    int en_cyc;
    int add_at;
    int dstart;
    int cyc;
    int bidx;
    int pat[6] = '{1, 1, 0, 1, 1, 1};
    logic mid_done;

    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    a_set(1'b0, 1'b0);
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.in_done = 1'b0; ifb.we_done = 1'b0;
    ifb.add_done = 1'b0; ifb.lif_ready = 1'b0; ifb.out_valid = 1'b0; ifb.spike_in = 1'b0;

    #12;
    a_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    a_zero_outputs("post-reset idle");

    run_a("run1");

    // Split fetch handshake; we_done on cycle 4 also lands on the watchdog limit.
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    en_cyc = 0;
    add_at = 0;
    for (int c = 1; c <= 5; c++) begin
      if (ifa.in_en && ifa.we_en) en_cyc++;
      if (ifa.add_en && (add_at == 0)) add_at = c;
      ifa.in_done = (c == 1);
      ifa.we_done = (c == 4);
      tick();
    end
    chk("split mem enable cycles", 32'(en_cyc), 4);
    chk("split add entry cycle", 32'(add_at), 5);
    chk("split no error", 32'(ifa.error), 0);

    a_set(1'b1, 1'b1);
    repeat (5) tick();
    chk("abort setup add_en", 32'(ifa.add_en), 1);
    chk("abort setup nidx", 32'(ifa.neuron_idx), 1);
    chk("abort setup sidx", 32'(ifa.step_idx), 0);
    dstart = a_done_total;
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk("abort busy", 32'(ifa.busy), 0);
    chk("abort add_en", 32'(ifa.add_en), 0);
    chk("abort count", 32'(ifa.spike_count), 1);
    repeat (3) tick();
    chk("abort stays idle", 32'(ifa.in_en), 0);
    chk("abort no done", 32'(a_done_total - dstart), 0);

    // Watchdog in LIF; other completions held high must not help.
    a_set(1'b1, 1'b1);
    ifa.lif_ready = 1'b0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    tick();
    tick();
    chk("wd lif entered", 32'(ifa.lif_en), 1);
    repeat (3) tick();
    chk("wd lif cycle4 lif_en", 32'(ifa.lif_en), 1);
    chk("wd lif cycle4 error", 32'(ifa.error), 0);
    tick();
    chk("wd error", 32'(ifa.error), 1);
    chk("wd lif_en off", 32'(ifa.lif_en), 0);
    chk("wd busy", 32'(ifa.busy), 0);
    chk("wd count frozen", 32'(ifa.spike_count), 0);
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    tick();
    chk("wd abort ignored", 32'(ifa.error), 1);
    a_set(1'b0, 1'b0);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("err restart error", 32'(ifa.error), 0);
    chk("err restart in_en", 32'(ifa.in_en), 1);
    chk("err restart nidx", 32'(ifa.neuron_idx), 0);
    chk("err restart sidx", 32'(ifa.step_idx), 0);
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk("err restart abort", 32'(ifa.busy), 0);

    // Async reset in OUT of neuron 1, after neuron 0 spiked.
    a_set(1'b1, 1'b1);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    repeat (8) tick();
    chk("pre-reset out_en", 32'(ifa.out_en), 1);
    chk("pre-reset nidx", 32'(ifa.neuron_idx), 1);
    chk("pre-reset count", 32'(ifa.spike_count), 1);
    #2;
    rst = 1'b0;
    #1;
    a_zero_outputs("async reset");
    a_set(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_a("rerun");

    // Saturating 2-bit counter on instance B: spikes 1,1,0,1,1,1.
    ifb.in_done = 1'b1; ifb.we_done = 1'b1; ifb.add_done = 1'b1;
    ifb.lif_ready = 1'b1; ifb.out_valid = 1'b1;
    ifb.start = 1'b1;
    dstart = b_done_total;
    cyc = 0;
    mid_done = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      bidx = int'(ifb.neuron_idx) + 3 * int'(ifb.step_idx);
      ifb.spike_in = (bidx < 6) ? pat[bidx][0] : 1'b0;
      tick();
      ifb.start = 1'b0;
      if (!mid_done && ifb.in_en && (ifb.neuron_idx == 2'd0) && (ifb.step_idx == 1'b1)) begin
        chk("sat mid count", 32'(ifb.spike_count), 2);
        mid_done = 1'b1;
      end
      if (ifb.done) begin
        cyc = k;
        break;
      end
    end
    chk("sat cycles to done", 32'(cyc), 31);
    chk("sat count", 32'(ifb.spike_count), 3);
    ifb.in_done = 1'b0; ifb.we_done = 1'b0; ifb.add_done = 1'b0;
    ifb.lif_ready = 1'b0; ifb.out_valid = 1'b0; ifb.spike_in = 1'b0;
    repeat (2) tick();
    chk("sat done pulses", 32'(b_done_total - dstart), 1);
    chk("sat count hold", 32'(ifb.spike_count), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
